// File: rtl/seven_seg_scheduler.sv
// Purpose : round-robin time-share of the single seven-segment digit among three pattern sources,
//           with a minimum hold time before a grant can be preempted.
// Latency : request-to-grant 1 cycle; granted pattern reaches o_Segments 1 cycle after i_Pattern.
// Backpressure: none. Requests are level-sensitive and not latched, so a source keeps i_Req high until granted.
// Ports   : i_Clk, i_Rst_L (async active-low), i_Req[2:0], i_Pattern[20:0] (source n at [7n+6:7n]),
//           o_Grant[2:0] (one-hot or zero), o_Segments[6:0] (registered, active-high), o_Busy (|o_Grant).
// Option  : SEG_SCHED_GAP_EN inserts g_GAP blank cycles after every release.
module seven_seg_scheduler #(
    parameter int unsigned g_HOLD = 25000000
`ifdef SEG_SCHED_GAP_EN
    ,
    parameter int unsigned g_GAP  = 2
`endif
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic [2:0]  i_Req,
    input  logic [20:0] i_Pattern,
    output logic [2:0]  o_Grant,
    output logic [6:0]  o_Segments,
    output logic        o_Busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
`ifdef SEG_SCHED_GAP_EN
        ST_GAP   = 2'd2,
`endif
        ST_GRANT = 2'd1
    } state_t;

    state_t      r_State;
    logic [2:0]  r_Grant;
    logic [6:0]  r_Seg;
    logic [1:0]  r_Owner;   // index of the granted source, valid in ST_GRANT
    logic [1:0]  r_Ptr;     // round-robin search start
    logic [31:0] r_Cnt;     // hold counter, reused as the gap counter

    logic [1:0]  w_Start;
    logic [1:0]  w_Win;
    logic        w_WinVld;
    logic        w_OwnReq;
    logic        w_Others;
    logic        w_Release;
    logic [6:0]  w_OwnPat;
    logic [6:0]  w_WinPat;

    function automatic logic [6:0] sel_pat(input logic [1:0] idx, input logic [20:0] pat);
        case (idx)
            2'd0:    sel_pat = pat[6:0];
            2'd1:    sel_pat = pat[13:7];
            2'd2:    sel_pat = pat[20:14];
            default: sel_pat = 7'd0;
        endcase
    endfunction

    function automatic logic [2:0] one_hot(input logic [1:0] idx);
        case (idx)
            2'd0:    one_hot = 3'b001;
            2'd1:    one_hot = 3'b010;
            2'd2:    one_hot = 3'b100;
            default: one_hot = 3'b000;
        endcase
    endfunction

    // Pointer value 3 cannot be reached but is folded onto 0 to stay safe.
    assign w_Start  = (r_Ptr == 2'd3) ? 2'd0 : r_Ptr;
    assign w_WinVld = |i_Req;

    // Search upward from the pointer with wrap.
    always_comb begin
        w_Win = 2'd0;
        case (w_Start)
            2'd1: begin
                if (i_Req[1])      w_Win = 2'd1;
                else if (i_Req[2]) w_Win = 2'd2;
                else               w_Win = 2'd0;
            end
            2'd2: begin
                if (i_Req[2])      w_Win = 2'd2;
                else if (i_Req[0]) w_Win = 2'd0;
                else               w_Win = 2'd1;
            end
            default: begin
                if (i_Req[0])      w_Win = 2'd0;
                else if (i_Req[1]) w_Win = 2'd1;
                else               w_Win = 2'd2;
            end
        endcase
    end

    always_comb begin
        w_OwnReq = 1'b0;
        case (r_Owner)
            2'd0:    w_OwnReq = i_Req[0];
            2'd1:    w_OwnReq = i_Req[1];
            2'd2:    w_OwnReq = i_Req[2];
            default: w_OwnReq = 1'b0;
        endcase
    end

    assign w_Others  = |(i_Req & ~r_Grant);
    // Dropping the request wins over everything; preemption only once the hold has expired.
    assign w_Release = !w_OwnReq || ((r_Cnt == g_HOLD) && w_Others);
    assign w_OwnPat  = sel_pat(r_Owner, i_Pattern);
    assign w_WinPat  = sel_pat(w_Win, i_Pattern);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State <= ST_IDLE;
            r_Grant <= 3'b000;
            r_Seg   <= 7'd0;
            r_Owner <= 2'd0;
            r_Ptr   <= 2'd0;
            r_Cnt   <= 32'd0;
        end else begin
            case (r_State)
                ST_IDLE: begin
                    r_Seg <= 7'd0;
                    if (w_WinVld) begin
                        r_State <= ST_GRANT;
                        r_Grant <= one_hot(w_Win);
                        r_Owner <= w_Win;
                        r_Seg   <= w_WinPat;
                        r_Cnt   <= 32'd0;
                    end
                end
                ST_GRANT: begin
                    if (w_Release) begin
                        r_Ptr   <= (r_Owner == 2'd0) ? 2'd1 : ((r_Owner == 2'd1) ? 2'd2 : 2'd0);
                        r_Grant <= 3'b000;
                        r_Seg   <= 7'd0;
                        r_Cnt   <= 32'd0;
`ifdef SEG_SCHED_GAP_EN
                        r_State <= ST_GAP;
`else
                        r_State <= ST_IDLE;
`endif
                    end else begin
                        r_Seg <= w_OwnPat;
                        if (r_Cnt != g_HOLD) begin
                            r_Cnt <= r_Cnt + 32'd1;
                        end
                    end
                end
`ifdef SEG_SCHED_GAP_EN
                ST_GAP: begin
                    r_Seg <= 7'd0;
                    // Leave after exactly g_GAP cycles in this state.
                    if ((r_Cnt + 32'd1) >= g_GAP) begin
                        r_State <= ST_IDLE;
                        r_Cnt   <= 32'd0;
                    end else begin
                        r_Cnt <= r_Cnt + 32'd1;
                    end
                end
`endif
                default: begin
                    r_State <= ST_IDLE;
                    r_Grant <= 3'b000;
                    r_Seg   <= 7'd0;
                    r_Cnt   <= 32'd0;
                end
            endcase
        end
    end

    assign o_Grant    = r_Grant;
    assign o_Segments = r_Seg;
    assign o_Busy     = |r_Grant;

endmodule

// File: tb/tb_seven_seg_scheduler.sv
// Directed bench for seven_seg_scheduler with g_HOLD=4 (and g_GAP=2 when SEG_SCHED_GAP_EN is set).
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_seven_seg_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [20:0] pat;
    logic [2:0]  gnt;
    logic [6:0]  seg;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

`ifdef SEG_SCHED_GAP_EN
    localparam int BLANK = 3;   // 2 gap cycles + 1 idle cycle
`else
    localparam int BLANK = 1;   // 1 idle cycle
`endif

    always #5 clk = ~clk;

    seven_seg_scheduler #(
        .g_HOLD(4)
`ifdef SEG_SCHED_GAP_EN
        ,
        .g_GAP (2)
`endif
    ) dut (
        .i_Clk     (clk),
        .i_Rst_L   (rst_n),
        .i_Req     (req),
        .i_Pattern (pat),
        .o_Grant   (gnt),
        .o_Segments(seg),
        .o_Busy    (busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] eg, input logic [6:0] es);
        logic eb;
        eb = (eg != 3'b000);
        vectors++;
        assert (gnt === eg) else begin
            miscompares++;
            $error("FAIL %s grant observed %b expected %b", tag, gnt, eg);
        end
        vectors++;
        assert (seg === es) else begin
            miscompares++;
            $error("FAIL %s segments observed %h expected %h", tag, seg, es);
        end
        vectors++;
        assert (busy === eb) else begin
            miscompares++;
            $error("FAIL %s busy observed %b expected %b", tag, busy, eb);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b000;
        pat   = {7'h5B, 7'h06, 7'h3F};

        // Reset and idle
        step;
        step;
        chk("reset", 3'b000, 7'h00);
        rst_n = 1'b1;
        repeat (10) begin
            step;
            chk("idle", 3'b000, 7'h00);
        end

        // Single requester held indefinitely
        req = 3'b001;
        step;
        chk("single_grant", 3'b001, 7'h3F);
        repeat (49) begin
            step;
            chk("single_hold", 3'b001, 7'h3F);
        end
        pat[6:0] = 7'h7F;
        step;
        chk("pattern_track", 3'b001, 7'h7F);
        pat[6:0] = 7'h3F;
        req = 3'b000;
        step;
        chk("single_drop", 3'b000, 7'h00);

        // Reset again so the pointer starts at 0, then preemption
        rst_n = 1'b0;
        step;
        chk("reset2", 3'b000, 7'h00);
        rst_n = 1'b1;
        req = 3'b011;
        step;
        chk("preempt_first", 3'b001, 7'h3F);
        repeat (4) begin
            step;
            chk("preempt_hold", 3'b001, 7'h3F);
        end
        for (int i = 0; i < BLANK; i++) begin
            step;
            chk("preempt_blank", 3'b000, 7'h00);
        end
        step;
        chk("preempt_next", 3'b010, 7'h06);

        // Source 1 drops; pointer moves to 2 so source 2 beats source 0
        req = 3'b101;
        for (int i = 0; i < BLANK; i++) begin
            step;
            chk("wrap_release", 3'b000, 7'h00);
        end
        step;
        chk("wrap_first", 3'b100, 7'h5B);
        repeat (4) begin
            step;
            chk("wrap_hold", 3'b100, 7'h5B);
        end
        for (int i = 0; i < BLANK; i++) begin
            step;
            chk("wrap_blank", 3'b000, 7'h00);
        end
        step;
        chk("wrap_second", 3'b001, 7'h3F);

        // Move the grant to source 1, then reset asynchronously mid-grant
        req = 3'b010;
        for (int i = 0; i < BLANK; i++) begin
            step;
            chk("drop_release", 3'b000, 7'h00);
        end
        step;
        chk("mid_grant", 3'b010, 7'h06);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 3'b000, 7'h00);
        req = 3'b111;
        step;
        chk("reset_hold", 3'b000, 7'h00);
        rst_n = 1'b1;
        step;
        chk("after_reset", 3'b001, 7'h3F);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
